// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared ALU operation codes, instruction opcode/funct values and
//             forward-select encoding for the ALU and its issue stage.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU operation codes; bit 2 is the subtract/invert control.
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Primary opcodes (instruction[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    // R-type function codes (instruction[5:0]).
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // Forward select; 2'b11 falls back to the register file.
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_decode
//  Purpose  : Combinational decode of opcode/funct into the ALU operation
//             code plus operand-B and branch qualifiers.
//  Ports    : opcode_i, funct_i   - instruction fields
//             signal_o            - 3-bit ALU op code
//             use_imm_o           - operand B comes from the immediate
//             is_beq_o            - branch-on-equal instruction
//             legal_o             - instruction is supported
//  Revision : 1.0 - initial release
// ============================================================================
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [2:0] signal_o,
    output logic       use_imm_o,
    output logic       is_beq_o,
    output logic       legal_o
);

    always_comb begin
        signal_o  = ALU_ADD;
        use_imm_o = 1'b0;
        is_beq_o  = 1'b0;
        legal_o   = 1'b1;
        case (opcode_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADD:  signal_o = ALU_ADD;
                    FN_SUB:  signal_o = ALU_SUB;
                    FN_AND:  signal_o = ALU_AND;
                    FN_OR:   signal_o = ALU_OR;
                    FN_SLT:  signal_o = ALU_SLT;
                    default: legal_o  = 1'b0;
                endcase
            end
            OP_LW, OP_SW, OP_ADDI: begin
                signal_o  = ALU_ADD;
                use_imm_o = 1'b1;
            end
            OP_BEQ: begin
                signal_o = ALU_SUB;
                is_beq_o = 1'b1;
            end
            default: legal_o = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_stage
//  Purpose  : ID/EX boundary register feeding the ALU. Decodes the ALU op,
//             selects forwarded operands, applies the immediate and handles
//             stall, flush and illegal-instruction reporting.
//  Ports    : clk, reset (sync, active-high)
//             id_valid, opcode, funct, rs_data, rt_data, imm_ext - ID inputs
//             fwd_a, fwd_b, ex_mem_result, mem_wb_result      - forwarding
//             stall, flush                                    - pipeline ctl
//             ex_valid, Signal, dataA, dataB, beq, illegal    - EX outputs
//  Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [WIDTH-1:0] imm_ext,
    input  logic [1:0]       fwd_a,
    input  logic [1:0]       fwd_b,
    input  logic [WIDTH-1:0] ex_mem_result,
    input  logic [WIDTH-1:0] mem_wb_result,
    input  logic             stall,
    input  logic             flush,
    output logic             ex_valid,
    output logic [2:0]       Signal,
    output logic [WIDTH-1:0] dataA,
    output logic [WIDTH-1:0] dataB,
    output logic             beq,
    output logic             illegal
);

    logic [2:0]       dec_signal;
    logic             dec_use_imm;
    logic             dec_is_beq;
    logic             dec_legal;
    logic [WIDTH-1:0] fwd_a_val;
    logic [WIDTH-1:0] fwd_b_val;

    logic             ex_valid_q, ex_valid_d;
    logic [2:0]       signal_q,   signal_d;
    logic [WIDTH-1:0] data_a_q,   data_a_d;
    logic [WIDTH-1:0] data_b_q,   data_b_d;
    logic             beq_q,      beq_d;
    logic             illegal_q,  illegal_d;

    alu_op_decode u_decode (
        .opcode_i  (opcode),
        .funct_i   (funct),
        .signal_o  (dec_signal),
        .use_imm_o (dec_use_imm),
        .is_beq_o  (dec_is_beq),
        .legal_o   (dec_legal)
    );

    // Forwarding muxes sit ahead of the register.
    always_comb begin
        case (fwd_a)
            FWD_EXMEM: fwd_a_val = ex_mem_result;
            FWD_MEMWB: fwd_a_val = mem_wb_result;
            default:   fwd_a_val = rs_data;
        endcase
        case (fwd_b)
            FWD_EXMEM: fwd_b_val = ex_mem_result;
            FWD_MEMWB: fwd_b_val = mem_wb_result;
            default:   fwd_b_val = rt_data;
        endcase
    end

    // Next-state: flush beats stall; anything not a legal valid instruction
    // becomes a bubble. Stall freezes the payload but always clears illegal
    // so the pulse is re-evaluated once the stall releases.
    always_comb begin
        ex_valid_d = 1'b0;
        signal_d   = ALU_ADD;
        data_a_d   = '0;
        data_b_d   = '0;
        beq_d      = 1'b0;
        illegal_d  = 1'b0;
        if (flush) begin
            // bubble, no illegal report
        end else if (stall) begin
            ex_valid_d = ex_valid_q;
            signal_d   = signal_q;
            data_a_d   = data_a_q;
            data_b_d   = data_b_q;
            beq_d      = beq_q;
        end else if (id_valid && dec_legal) begin
            ex_valid_d = 1'b1;
            signal_d   = dec_signal;
            data_a_d   = fwd_a_val;
            data_b_d   = dec_use_imm ? imm_ext : fwd_b_val;
            beq_d      = dec_is_beq;
        end else begin
            illegal_d  = id_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            signal_q   <= ALU_ADD;
            data_a_q   <= '0;
            data_b_q   <= '0;
            beq_q      <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            signal_q   <= signal_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            beq_q      <= beq_d;
            illegal_q  <= illegal_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign Signal   = signal_q;
    assign dataA    = data_a_q;
    assign dataB    = data_b_q;
    assign beq      = beq_q;
    assign illegal  = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_stage
//  Purpose  : Directed, table-driven self-checking bench for alu_issue_stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

    typedef struct {
        logic        rst;
        logic        idv;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] xm;
        logic [31:0] mw;
        logic        st;
        logic        fl;
        logic        e_v;
        logic [2:0]  e_sig;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic        e_beq;
        logic        e_ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm_ext;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [31:0] ex_mem_result;
    logic [31:0] mem_wb_result;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [2:0]  Signal;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        beq;
    logic        illegal;

    int n_vec = 0;
    int n_err = 0;

    localparam int NV = 23;
    vec_t tbl [NV];

    alu_issue_stage #(.WIDTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .opcode        (opcode),
        .funct         (funct),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .imm_ext       (imm_ext),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .ex_mem_result (ex_mem_result),
        .mem_wb_result (mem_wb_result),
        .stall         (stall),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .Signal        (Signal),
        .dataA         (dataA),
        .dataB         (dataB),
        .beq           (beq),
        .illegal       (illegal)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic rst, input logic idv, input logic [5:0] op, input logic [5:0] fn,
        input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
        input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] xm, input logic [31:0] mw,
        input logic st, input logic fl,
        input logic e_v, input logic [2:0] e_sig, input logic [31:0] e_a, input logic [31:0] e_b,
        input logic e_beq, input logic e_ill);
        vec_t v;
        v.rst = rst; v.idv = idv; v.op = op; v.fn = fn;
        v.rs = rs; v.rt = rt; v.imm = imm; v.fa = fa; v.fb = fb;
        v.xm = xm; v.mw = mw; v.st = st; v.fl = fl;
        v.e_v = e_v; v.e_sig = e_sig; v.e_a = e_a; v.e_b = e_b;
        v.e_beq = e_beq; v.e_ill = e_ill;
        return v;
    endfunction

    // Drive inputs on the falling edge, sample 1 time unit after the rising edge.
    task automatic apply(input vec_t v, input string nm);
        @(negedge clk);
        reset = v.rst; id_valid = v.idv; opcode = v.op; funct = v.fn;
        rs_data = v.rs; rt_data = v.rt; imm_ext = v.imm;
        fwd_a = v.fa; fwd_b = v.fb; ex_mem_result = v.xm; mem_wb_result = v.mw;
        stall = v.st; flush = v.fl;
        @(posedge clk);
        #1;
        n_vec++;
        if (ex_valid !== v.e_v || Signal !== v.e_sig || dataA !== v.e_a ||
            dataB !== v.e_b || beq !== v.e_beq || illegal !== v.e_ill) begin
            n_err++;
            $display("FAIL %s: got v=%b sig=%b a=%h b=%h beq=%b ill=%b, want v=%b sig=%b a=%h b=%h beq=%b ill=%b",
                     nm, ex_valid, Signal, dataA, dataB, beq, illegal,
                     v.e_v, v.e_sig, v.e_a, v.e_b, v.e_beq, v.e_ill);
        end
    endtask

    initial begin
        // rst idv op fn rs rt imm fa fb xm mw st fl | v sig a b beq ill
        tbl[0]  = mk(1,0,6'b000000,6'b000000,32'h0,32'h0,32'h0,2'b00,2'b00,32'h0,32'h0,0,0, 0,3'b010,32'h0,32'h0,0,0);
        tbl[1]  = mk(1,1,6'b000000,6'b100000,32'h5,32'h6,32'h0,2'b00,2'b00,32'h0,32'h0,0,0, 0,3'b010,32'h0,32'h0,0,0);
        tbl[2]  = mk(0,0,6'b000000,6'b100000,32'h5,32'h6,32'h0,2'b00,2'b00,32'h0,32'h0,0,0, 0,3'b010,32'h0,32'h0,0,0);
        tbl[3]  = mk(0,1,6'b000000,6'b100010,32'h9,32'h4,32'h0,2'b00,2'b00,32'h0,32'h0,0,0, 1,3'b110,32'h9,32'h4,0,0);
        tbl[4]  = mk(0,1,6'b100011,6'b111100,32'h123,32'h77,32'hFFFF_FFFC,2'b01,2'b00,32'h1000_0000,32'hDEAD,0,0, 1,3'b010,32'h1000_0000,32'hFFFF_FFFC,0,0);
        tbl[5]  = mk(0,1,6'b000100,6'b000000,32'h7,32'h99,32'h4,2'b00,2'b10,32'hAAAA,32'h55,0,0, 1,3'b110,32'h7,32'h55,1,0);
        tbl[6]  = mk(0,1,6'b000000,6'b100000,32'h3,32'h5,32'h0,2'b00,2'b00,32'h0,32'h0,0,0, 1,3'b010,32'h3,32'h5,0,0);
        tbl[7]  = mk(0,1,6'b000000,6'b100010,32'h8,32'h1,32'h0,2'b00,2'b00,32'h0,32'h0,1,0, 1,3'b010,32'h3,32'h5,0,0);
        tbl[8]  = mk(0,1,6'b111111,6'b000000,32'hF,32'hE,32'h0,2'b01,2'b10,32'h1,32'h2,1,0, 1,3'b010,32'h3,32'h5,0,0);
        tbl[9]  = mk(0,0,6'b000100,6'b000000,32'hC,32'hD,32'h0,2'b00,2'b00,32'h0,32'h0,1,0, 1,3'b010,32'h3,32'h5,0,0);
        tbl[10] = mk(0,1,6'b000000,6'b100000,32'h1,32'h2,32'h0,2'b00,2'b00,32'h0,32'h0,1,1, 0,3'b010,32'h0,32'h0,0,0);
        tbl[11] = mk(0,1,6'b111111,6'b000000,32'h1,32'h2,32'h0,2'b00,2'b00,32'h0,32'h0,0,0, 0,3'b010,32'h0,32'h0,0,1);
        tbl[12] = mk(0,0,6'b111111,6'b000000,32'h1,32'h2,32'h0,2'b00,2'b00,32'h0,32'h0,0,0, 0,3'b010,32'h0,32'h0,0,0);
        tbl[13] = mk(0,1,6'b111111,6'b000000,32'h1,32'h2,32'h0,2'b00,2'b00,32'h0,32'h0,0,1, 0,3'b010,32'h0,32'h0,0,0);
        tbl[14] = mk(0,1,6'b000000,6'b000000,32'h1,32'h2,32'h0,2'b00,2'b00,32'h0,32'h0,0,0, 0,3'b010,32'h0,32'h0,0,1);
        tbl[15] = mk(0,1,6'b000000,6'b100100,32'hF0F0,32'h0FF0,32'h0,2'b11,2'b11,32'h1111,32'h2222,0,0, 1,3'b000,32'hF0F0,32'h0FF0,0,0);
        tbl[16] = mk(0,1,6'b000000,6'b100101,32'h1,32'h2,32'h0,2'b10,2'b00,32'h9999,32'h1234,0,0, 1,3'b001,32'h1234,32'h2,0,0);
        tbl[17] = mk(0,1,6'b000000,6'b101010,32'h5,32'h6,32'h0,2'b00,2'b01,32'hFFFF_FFFF,32'h0,0,0, 1,3'b111,32'h5,32'hFFFF_FFFF,0,0);
        tbl[18] = mk(0,1,6'b001000,6'b000000,32'h10,32'h3,32'hFFFF_FFFF,2'b00,2'b01,32'h4444,32'h0,0,0, 1,3'b010,32'h10,32'hFFFF_FFFF,0,0);
        tbl[19] = mk(0,1,6'b101011,6'b001000,32'h20,32'h30,32'h8,2'b00,2'b00,32'h0,32'h0,0,0, 1,3'b010,32'h20,32'h8,0,0);
        tbl[20] = mk(0,1,6'b111110,6'b000000,32'h1,32'h1,32'h0,2'b00,2'b00,32'h0,32'h0,1,0, 1,3'b010,32'h20,32'h8,0,0);
        tbl[21] = mk(0,1,6'b111110,6'b000000,32'h1,32'h1,32'h0,2'b00,2'b00,32'h0,32'h0,0,0, 0,3'b010,32'h0,32'h0,0,1);
        tbl[22] = mk(0,0,6'b111110,6'b000000,32'h1,32'h1,32'h0,2'b00,2'b00,32'h0,32'h0,0,0, 0,3'b010,32'h0,32'h0,0,0);

        reset = 1'b1; id_valid = 1'b0; opcode = '0; funct = '0;
        rs_data = '0; rt_data = '0; imm_ext = '0; fwd_a = '0; fwd_b = '0;
        ex_mem_result = '0; mem_wb_result = '0; stall = 1'b0; flush = 1'b0;

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a stall wins over the hold.
        apply(mk(0,1,6'b000000,6'b100010,32'hA,32'hB,32'h0,2'b00,2'b00,32'h0,32'h0,0,0, 1,3'b110,32'hA,32'hB,0,0), "load_before_stall");
        apply(mk(0,1,6'b000000,6'b100000,32'h1,32'h2,32'h0,2'b00,2'b00,32'h0,32'h0,1,0, 1,3'b110,32'hA,32'hB,0,0), "stall_hold");
        apply(mk(1,1,6'b000000,6'b100000,32'h1,32'h2,32'h0,2'b00,2'b00,32'h0,32'h0,1,0, 0,3'b010,32'h0,32'h0,0,0), "reset_mid_stall");

        // Reset with an illegal instruction and flush: no pulse, reset state.
        apply(mk(0,1,6'b000100,6'b000000,32'h6,32'h6,32'h0,2'b00,2'b00,32'h0,32'h0,0,0, 1,3'b110,32'h6,32'h6,1,0), "beq_load");
        apply(mk(1,1,6'b111111,6'b000000,32'h1,32'h2,32'h0,2'b00,2'b00,32'h0,32'h0,0,1, 0,3'b010,32'h0,32'h0,0,0), "reset_mid_flush");
        apply(mk(0,1,6'b000000,6'b100100,32'hFF,32'h0F,32'h0,2'b00,2'b00,32'h0,32'h0,0,0, 1,3'b000,32'hFF,32'h0F,0,0), "after_reset_load");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue_stage.md
# alu_issue_stage

ID/EX pipeline stage that drives the 32-bit ALU's operation and operand interface. Each cycle it decodes opcode/funct into the 3-bit ALU `Signal` code, selects forwarded operands, applies the immediate, and registers everything into the EX stage. It owns the stall, flush and illegal-instruction handling for that boundary, and sits between the decode and register-read logic and the ALU in the five-stage pipeline.

## Interface
- `WIDTH`, 32: datapath width; `dataA`/`dataB` width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `id_valid`  in  1  ID holds a real instruction.
- `opcode`  in  6  instruction[31:26].
- `funct`  in  6  instruction[5:0].
- `rs_data`, `rt_data`  in  WIDTH  register-file read data.
- `imm_ext`  in  WIDTH  sign-extended immediate.
- `fwd_a`, `fwd_b`  in  2  forward select: 00 regfile, 01 `ex_mem_result`, 10 `mem_wb_result`, 11 regfile.
- `ex_mem_result`, `mem_wb_result`  in  WIDTH  forwarded values.
- `stall`  in  1  hold the EX register.
- `flush`  in  1  insert a bubble.
- `ex_valid`  out  1  EX register holds a real instruction.
- `Signal`  out  3  ALU op code.
- `dataA`, `dataB`  out  WIDTH  ALU operands.
- `beq`  out  1  branch-compare qualifier to the ALU zero output.
- `illegal`  out  1  one-cycle pulse for an unsupported instruction.

## Operation
- ALU codes, shared with the ALU: AND=000, OR=001, ADD=010, SUB=110, SLT=111. `Signal[2]` is the subtract/invert bit.
- Decode of opcode 000000 (R-type) by funct:
  - 100000 → ADD
  - 100010 → SUB
  - 100100 → AND
  - 100101 → OR
  - 101010 → SLT
  - any other funct is illegal.
- Decode of other opcodes:
  - 100011 (lw), 101011 (sw), 001000 (addi) → ADD, B = `imm_ext`.
  - 000100 (beq) → SUB, B = forwarded rt, `beq`=1.
  - any other opcode is illegal.
- Operand A is the forwarded rs value. Operand B is the forwarded rt value for R-type and beq, and `imm_ext` for lw, sw and addi.
- Load rule when `stall`=0 and `flush`=0:
  - legal instruction with `id_valid`=1: register all fields and set `ex_valid`=1.
  - `id_valid`=0: load a bubble.
- Bubble contents: `ex_valid`=0, `Signal`=ADD, `dataA`=`dataB`=0, `beq`=0.
- Illegal instruction with `id_valid`=1: load a bubble and assert `illegal` for exactly that one cycle.
- `stall`=1: every output holds its value. `illegal` is forced to 0 and is re-evaluated when the stall releases.
- `flush`=1: load a bubble, with no `illegal` pulse.
- Priority: `reset` > `flush` > `stall` > normal load.

## Timing
- Latency is 1 cycle: an ID-stage input sampled at edge N appears on the outputs after edge N.
- Reset values: `ex_valid`=0, `Signal`=010, `dataA`=0, `dataB`=0, `beq`=0, `illegal`=0.
- `reset` asserted mid-stall or mid-flush: the bubble/reset state is loaded at the next edge regardless of the other inputs.
- `flush` and `stall` asserted in the same cycle: a bubble is loaded (flush wins).
- Forwarding is combinational ahead of the register. No multi-cycle paths.
- There are no other state or counters beyond the registered outputs.

## Structure
- Package `alu_pkg` holds:
  - the ALU op localparams (`ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`);
  - the opcode and funct localparams;
  - the forward-select encoding.
- The ALU imports the same package, so the codes are defined once.
- One combinational sub-module, `alu_op_decode` (opcode, funct → `Signal`, `use_imm`, `is_beq`, `legal`), instantiated once.
- The operand muxes and the EX register stay in the top module.

## Test plan
- Reset then idle: hold `reset` 2 cycles → all outputs at reset values. Release with `id_valid`=0 → `ex_valid`=0.
- R-type sub: funct 100010, rs=0x0000_0009, rt=0x0000_0004, fwd 00/00 → next cycle `Signal`=110, `dataA`=9, `dataB`=4, `ex_valid`=1, `beq`=0.
- lw with forwarding: opcode 100011, `fwd_a`=01, `ex_mem_result`=0x1000_0000, `imm_ext`=0xFFFF_FFFC → `Signal`=010, `dataA`=0x1000_0000, `dataB`=0xFFFF_FFFC.
- beq with MEM/WB forward: opcode 000100, `fwd_b`=10, `mem_wb_result`=0x55 → `Signal`=110, `beq`=1, `dataB`=0x55.
- Stall then flush: load an add, then hold `stall` 3 cycles while the inputs change → outputs frozen. Next cycle assert `stall`=1 and `flush`=1 together → bubble loaded.
- Illegal: opcode 111111 with `id_valid`=1 → `illegal`=1 for exactly one cycle and `ex_valid`=0. The same instruction under `flush` → `illegal`=0.
